transmit_arbiter: RTL and testbench
===================================

// Module: transmit_arbiter
// PURPOSE
//  Round-robin arbiter that shares one UART transmitter among N byte-stream
//  requesters. A grant is held for a whole message and released on the byte
//  flagged last, or on an idle timeout. Sits between on-chip message sources
//  and the transmit stb/dat/rdy port on the icestick top level.
// PARAMETERS
//  N        4     number of requesters, 2..16
//  TIMEOUT  1200  idle cycles mid-message before forced release; 0 = never
// PORTS
//  clk      in   1    system clock (12 MHz on icestick)
//  rst      in   1    synchronous reset, active high
//  req_stb  in   N    requester i has a byte on req_dat[8i+7:8i]
//  req_dat  in   8*N  requester bytes, packed LSB-first by index
//  req_lst  in   N    requester i's current byte ends its message
//  req_rdy  out  N    byte of requester i accepted this cycle
//  xmt_stb  out  1    byte valid toward transmitter
//  xmt_dat  out  8    byte toward transmitter
//  xmt_rdy  in   1    transmitter accepts byte (transfer = xmt_stb & xmt_rdy)
//  gnt      out  N    one-hot current grant; 0 when idle
//  bsy      out  1    grant held (state != IDLE)
// BEHAVIOUR
//  - Reset: state IDLE, gnt=0, ptr=0, timer=0, xmt_stb=0, xmt_dat=0, req_rdy=0, bsy=0.
//  - Handshake is stb/rdy on both sides; a transfer occurs when stb&rdy are high
//    at a rising edge. Requesters hold stb/dat/lst stable until rdy.
//  - States: IDLE, TAG (ARBITER_TAG_EN only), PASS.
//  - IDLE: xmt_stb=0, req_rdy=0. If any req_stb, select the first i with
//    req_stb[i] scanning ptr, ptr+1, ... mod N; next cycle gnt=onehot(i),
//    state=PASS (TAG if enabled). Arbitration latency: 1 cycle.
//  - PASS (grant g), combinational pass-through: xmt_stb=req_stb[g],
//    xmt_dat=req_dat[g], req_rdy[g]=xmt_rdy&req_stb[g], other req_rdy=0.
//  - Transfer with req_lst[g]=1 -> IDLE, gnt=0, ptr=(g+1) mod N. Re-arbitration
//    occurs in IDLE, so back-to-back messages carry one idle cycle.
//  - Timer: cleared on each transfer and on entry to PASS; increments while
//    PASS and req_stb[g]=0. When timer reaches TIMEOUT-1 and TIMEOUT!=0 -> IDLE,
//    ptr=(g+1) mod N. Timer saturates; it does not count in TAG or IDLE.
//  - Non-granted requesters' stb is ignored; no starvation: each waiting
//    requester is served within N messages.
//  - Simultaneous lst-transfer and timeout expiry: lst release wins (same result).
//  - Reset mid-message: grant dropped immediately; partial message is
//    truncated and not resumed (requester must restart).
//  - xmt_dat outside PASS/TAG is 0.
// CONFIGURATION
//  ARBITER_TAG_EN defined: after grant, state TAG drives xmt_stb=1,
//    xmt_dat={4'hA, idx(g)} (idx zero-extended to 4 bits); req_rdy=0. On
//    xmt_rdy -> PASS. Each message on the line is prefixed by one tag byte.
//  ARBITER_TAG_EN undefined: TAG state absent; IDLE goes directly to PASS.
// TESTING
//  1 Reset: rst=1 two cycles with req_stb=4'hF -> gnt=0, xmt_stb=0, req_rdy=0.
//  2 Single requester: req1 sends 3 bytes 8'h11,8'h22,8'h33 (lst on 8'h33),
//    xmt_rdy=1 -> gnt=4'b0010 one cycle after stb; bytes out in order; gnt=0 after.
//  3 Round robin: all four req_stb high, 1-byte messages (lst=1) -> grant order
//    0,1,2,3,0; no requester granted twice before others.
//  4 Backpressure: xmt_rdy low 5 cycles mid-message -> xmt_stb/xmt_dat held,
//    req_rdy=0, no byte lost or duplicated; timer stays 0.
//  5 Timeout: TIMEOUT=8, req2 sends 1 byte (lst=0) then drops stb -> after 8
//    idle cycles gnt=0, next pending req3 granted.
//  6 Tag (ARBITER_TAG_EN): req3 sends 8'h55 lst=1 -> line sees 8'hA3 then 8'h55.

Source files
------------

// File: rtl/transmit_arbiter_if.sv
// Handshake bundle between message requesters, the arbiter and the UART transmitter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface transmit_arbiter_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0]   req_stb;
    logic [8*N-1:0] req_dat;
    logic [N-1:0]   req_lst;
    logic [N-1:0]   req_rdy;
    logic           xmt_stb;
    logic [7:0]     xmt_dat;
    logic           xmt_rdy;
    logic [N-1:0]   gnt;
    logic           bsy;

    modport master (
        input  req_stb, req_dat, req_lst, xmt_rdy,
        output req_rdy, xmt_stb, xmt_dat, gnt, bsy
    );

    modport slave (
        output req_stb, req_dat, req_lst, xmt_rdy,
        input  req_rdy, xmt_stb, xmt_dat, gnt, bsy
    );
endinterface

// File: rtl/transmit_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte-stream requesters.
// A grant covers a whole message; it ends on the byte flagged last or after TIMEOUT
// idle cycles mid-message (TIMEOUT = 0 disables the timeout).
// Optional feature macro: ARBITER_TAG_EN prefixes each message with {4'hA, index}.
module transmit_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 1200
) (
    input  logic               clk,
    input  logic               rst,
    transmit_arbiter_if.master bus
);
    localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW   = $clog2(TIMEOUT + 2);
    localparam int unsigned TMAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [N-1:0] One = 1;

    typedef enum logic [1:0] {
        StIdle,
`ifdef ARBITER_TAG_EN
        StTag,
`endif
        StPass
    } state_e;

    state_e        state_q;
    logic [IW-1:0] gidx_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] ptr_q;
    logic [TW-1:0] timer_q;

    logic [IW-1:0] pick;
    logic          any_req;
    logic          g_stb;
    logic          g_lst;
    logic [7:0]    g_dat;
    logic          xfer;
    logic [IW-1:0] ptr_nxt;

    // Round-robin pick: first requester at or after ptr; scanning backwards lets the
    // nearest one win by being assigned last.
    always_comb begin
        int idx;
        pick    = ptr_q;
        any_req = 1'b0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % int'(N);
            if (bus.req_stb[idx]) begin
                pick    = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign g_stb   = bus.req_stb[gidx_q];
    assign g_lst   = bus.req_lst[gidx_q];
    assign g_dat   = bus.req_dat[8*int'(gidx_q) +: 8];
    assign xfer    = (state_q == StPass) && g_stb && bus.xmt_rdy;
    assign ptr_nxt = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;

    // Grant FSM: arbitration, message release and idle timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gidx_q  <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        gidx_q  <= pick;
                        gnt_q   <= One << pick;
                        timer_q <= '0;
`ifdef ARBITER_TAG_EN
                        state_q <= StTag;
`else
                        state_q <= StPass;
`endif
                    end
                end
`ifdef ARBITER_TAG_EN
                StTag: begin
                    if (bus.xmt_rdy) begin
                        timer_q <= '0;
                        state_q <= StPass;
                    end
                end
`endif
                StPass: begin
                    if (xfer) begin
                        timer_q <= '0;
                        if (g_lst) begin
                            state_q <= StIdle;
                            gnt_q   <= '0;
                            ptr_q   <= ptr_nxt;
                        end
                    end else if (!g_stb) begin
                        if ((TIMEOUT != 0) && (timer_q == TW'(TMAX))) begin
                            state_q <= StIdle;
                            gnt_q   <= '0;
                            ptr_q   <= ptr_nxt;
                        end else if (timer_q != '1) begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    // Line-side outputs: pass-through of the granted requester, tag byte when enabled.
    always_comb begin
        bus.xmt_stb = 1'b0;
        bus.xmt_dat = 8'h00;
        bus.req_rdy = '0;
        unique case (state_q)
`ifdef ARBITER_TAG_EN
            StTag: begin
                bus.xmt_stb = 1'b1;
                bus.xmt_dat = {4'hA, 4'(gidx_q)};
            end
`endif
            StPass: begin
                bus.xmt_stb         = g_stb;
                bus.xmt_dat         = g_dat;
                bus.req_rdy[gidx_q] = bus.xmt_rdy & g_stb;
            end
            default: ;
        endcase
    end

    assign bus.gnt = gnt_q;
    assign bus.bsy = (state_q != StIdle);
endmodule

// File: tb/tb_transmit_arbiter.sv
// Bench for transmit_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a message-level reference model.
module tb_transmit_arbiter;
    localparam int unsigned N       = 4;
    localparam int unsigned TIMEOUT = 8;
`ifdef ARBITER_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    transmit_arbiter_if #(.N(N)) bus ();

    transmit_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.req_stb = '0;
        bus.req_lst = '0;
        bus.req_dat = '0;
        bus.xmt_rdy = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference model: owner (-1 = nobody), rotating start point, idle-cycle count
    // since the last byte, and whether the tag byte is still owed.
    int m_own   = -1;
    int m_ptr   = 0;
    int m_quiet = 0;
    bit m_tag   = 1'b0;

    always @(posedge clk) begin
        int pick;
        if (rst) begin
            m_own   <= -1;
            m_ptr   <= 0;
            m_quiet <= 0;
            m_tag   <= 1'b0;
        end else if (m_own < 0) begin
            pick = -1;
            for (int k = 0; k < N; k++)
                if (pick < 0 && bus.req_stb[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            if (pick >= 0) begin
                m_own   <= pick;
                m_tag   <= TAG;
                m_quiet <= 0;
            end
        end else if (m_tag) begin
            if (bus.xmt_rdy) m_tag <= 1'b0;
        end else if (bus.req_stb[m_own] && bus.xmt_rdy) begin
            m_quiet <= 0;
            if (bus.req_lst[m_own]) begin
                m_own <= -1;
                m_ptr <= (m_own + 1) % N;
            end
        end else if (!bus.req_stb[m_own]) begin
            if (TIMEOUT != 0 && m_quiet + 1 >= TIMEOUT) begin
                m_own <= -1;
                m_ptr <= (m_own + 1) % N;
            end else begin
                m_quiet <= m_quiet + 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [31:0] e_gnt, e_dat, e_rdy;
        logic        e_stb;
        if (!rst) begin
            e_gnt = (m_own < 0) ? 0 : (1 << m_own);
            if (m_own < 0) begin
                e_stb = 1'b0; e_dat = 0; e_rdy = 0;
            end else if (m_tag) begin
                e_stb = 1'b1; e_dat = 32'hA0 | m_own; e_rdy = 0;
            end else begin
                e_stb = bus.req_stb[m_own];
                e_dat = {24'h0, bus.req_dat[8*m_own +: 8]};
                e_rdy = (bus.xmt_rdy && e_stb) ? (1 << m_own) : 0;
            end
            chk("model gnt", bus.gnt, e_gnt);
            chk("model bsy", bus.bsy, (m_own >= 0));
            chk("model xmt_stb", bus.xmt_stb, e_stb);
            chk("model xmt_dat", bus.xmt_dat, e_dat);
            chk("model req_rdy", bus.req_rdy, e_rdy);
        end
    end

    int          rem [N];
    int          gap [N];
    logic [N-1:0] acc;

    initial begin
        // Reset with all requesters asking.
        rst = 1'b1;
        bus.req_stb = 4'hF;
        bus.req_lst = 4'hF;
        bus.req_dat = 32'hDEAD_BEEF;
        bus.xmt_rdy = 1'b1;
        tick();
        tick();
        #1;
        chk("reset gnt", bus.gnt, 0);
        chk("reset xmt_stb", bus.xmt_stb, 0);
        chk("reset req_rdy", bus.req_rdy, 0);
        chk("reset bsy", bus.bsy, 0);
        rst = 1'b0;
        idle_in();

        // Single requester, three-byte message.
        tick();
        bus.req_stb = 4'b0010;
        bus.req_dat = 32'h0000_1100;
        #1 chk("single latency gnt", bus.gnt, 0);
        tick();
        #1 chk("single gnt", bus.gnt, 4'b0010);
`ifdef ARBITER_TAG_EN
        chk("single tag", bus.xmt_dat, 8'hA1);
        tick();
        #1;
`endif
        chk("single stb", bus.xmt_stb, 1);
        chk("single byte0", bus.xmt_dat, 8'h11);
        chk("single rdy", bus.req_rdy, 4'b0010);
        tick();
        bus.req_dat = 32'h0000_2200;
        #1 chk("single byte1", bus.xmt_dat, 8'h22);
        tick();
        bus.req_dat = 32'h0000_3300;
        bus.req_lst = 4'b0010;
        #1 chk("single byte2", bus.xmt_dat, 8'h33);
        tick();
        idle_in();
        #1 chk("single release gnt", bus.gnt, 0);

        // Round robin with everyone sending one-byte messages.
        do_reset();
        bus.req_stb = 4'hF;
        bus.req_lst = 4'hF;
        bus.req_dat = 32'h4433_2211;
        for (int m = 0; m < 5; m++) begin
            tick();
`ifdef ARBITER_TAG_EN
            tick();
`endif
            #1 chk("rr gnt", bus.gnt, 1 << (m % 4));
            tick();
        end
        idle_in();

        // Backpressure mid-message.
        do_reset();
        bus.req_stb = 4'b0001;
        bus.req_dat = 32'h0000_00A0;
        tick();
`ifdef ARBITER_TAG_EN
        tick();
`endif
        #1 chk("bp first rdy", bus.req_rdy, 4'b0001);
        tick();
        bus.req_dat = 32'h0000_00A1;
        bus.xmt_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp hold stb", bus.xmt_stb, 1);
            chk("bp hold dat", bus.xmt_dat, 8'hA1);
            chk("bp hold rdy", bus.req_rdy, 0);
            tick();
        end
        bus.xmt_rdy = 1'b1;
        #1 chk("bp resume rdy", bus.req_rdy, 4'b0001);
        tick();
        bus.req_dat = 32'h0000_00A2;
        bus.req_lst = 4'b0001;
        #1 chk("bp last dat", bus.xmt_dat, 8'hA2);
        tick();
        idle_in();
        #1 chk("bp release gnt", bus.gnt, 0);

        // Idle timeout: req2 stalls after one byte, req3 waits.
        do_reset();
        bus.req_stb = 4'b0100;
        bus.req_dat = 32'h0066_0000;
        tick();
`ifdef ARBITER_TAG_EN
        tick();
`endif
        #1 chk("to gnt", bus.gnt, 4'b0100);
        tick();
        bus.req_stb = 4'b1000;
        bus.req_dat = 32'h7700_0000;
        bus.req_lst = 4'b1000;
        for (int c = 0; c < 7; c++) tick();
        #1 chk("to still held", bus.gnt, 4'b0100);
        tick();
        #1 chk("to released", bus.gnt, 0);
        tick();
        #1 chk("to next gnt", bus.gnt, 4'b1000);
`ifdef ARBITER_TAG_EN
        tick();
        #1;
`endif
        chk("to next dat", bus.xmt_dat, 8'h77);
        tick();
        idle_in();

`ifdef ARBITER_TAG_EN
        // Tag prefix.
        do_reset();
        bus.req_stb = 4'b1000;
        bus.req_dat = 32'h5500_0000;
        bus.req_lst = 4'b1000;
        tick();
        #1;
        chk("tag stb", bus.xmt_stb, 1);
        chk("tag byte", bus.xmt_dat, 8'hA3);
        chk("tag rdy", bus.req_rdy, 0);
        tick();
        #1;
        chk("tag payload", bus.xmt_dat, 8'h55);
        chk("tag payload rdy", bus.req_rdy, 4'b1000);
        tick();
        idle_in();
`endif

        // Randomized traffic with gaps, backpressure and one mid-run reset.
        do_reset();
        for (int i = 0; i < N; i++) begin
            rem[i] = $urandom_range(1, 4);
            gap[i] = $urandom_range(0, 3);
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.xmt_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.req_stb[i]) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else begin
                        bus.req_stb[i]         = 1'b1;
                        bus.req_dat[8*i +: 8]  = 8'($urandom);
                        bus.req_lst[i]         = (rem[i] == 1);
                    end
                end
            end
            if (cyc == 1500) rst = 1'b1;
            #3;
            acc = rst ? '0 : (bus.req_rdy & bus.req_stb);
            tick();
            rst = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) begin
                        rem[i] = $urandom_range(1, 4);
                        gap[i] = $urandom_range(0, 3);
                    end else begin
                        gap[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 12) : 0;
                    end
                    bus.req_stb[i] = 1'b0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
